// File: rtl/usb_rx_pkg.sv
// Shared types for the USB 1.1 receive path.
// Status bundle handed from the RX byte FIFO to the protocol layer.
package usb_rx_pkg;

    localparam int USB_BYTE_W = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } rx_fifo_status_t;

endpackage

// File: rtl/fifo_ptr_ctr.sv
// FIFO pointer with an extra wrap bit above the address bits.
// Increments on inc_i, returns to zero on a synchronous clear.
module fifo_ptr_ctr #(
    parameter int PTR_W = 3
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           clr_i,
    input  logic           inc_i,
    output logic [PTR_W:0] ptr_o
);

    logic [PTR_W:0] ptr_q;
    logic [PTR_W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/usb_rx_byte_fifo.sv
// Synchronous byte FIFO between the RX byte assembler and the packet layer.
// Registered read port, sticky error flags, synchronous flush on EOP/abort.
module usb_rx_byte_fifo
    import usb_rx_pkg::*;
#(
    parameter int DATA_W   = USB_BYTE_W,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     w_en,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     r_en,
    output logic [DATA_W-1:0]        r_data,
    output logic                     r_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("usb_rx_byte_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_af_chk
        $error("usb_rx_byte_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [PTR_W:0]    w_ptr;
    logic [PTR_W:0]    r_ptr;
    logic [PTR_W:0]    cnt;
    logic              rd_ok;
    logic              wr_ok;
    rx_fifo_status_t   st;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] r_data_d;
    logic              r_valid_q;
    logic              r_valid_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign rd_ok = r_en & ~st.empty & ~clear;
    assign wr_ok = w_en & (~st.full | rd_ok) & ~clear;

    fifo_ptr_ctr #(.PTR_W(PTR_W)) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (clear),
        .inc_i (wr_ok),
        .ptr_o (w_ptr)
    );

    fifo_ptr_ctr #(.PTR_W(PTR_W)) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (clear),
        .inc_i (rd_ok),
        .ptr_o (r_ptr)
    );

    assign cnt            = w_ptr - r_ptr;
    assign st.empty       = (w_ptr == r_ptr);
    assign st.full        = (w_ptr[PTR_W-1:0] == r_ptr[PTR_W-1:0])
                          & (w_ptr[PTR_W] != r_ptr[PTR_W]);
    assign st.almost_full = (cnt >= (PTR_W+1)'(AF_LEVEL));
    assign st.overflow    = ovf_q;
    assign st.underflow   = unf_q;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[w_ptr[PTR_W-1:0]] <= w_data;
        end
    end

    always_comb begin
        r_data_d  = r_data_q;
        r_valid_d = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (rd_ok) begin
                r_data_d  = mem_q[r_ptr[PTR_W-1:0]];
                r_valid_d = 1'b1;
            end
            if (w_en & st.full & ~rd_ok) begin
                ovf_d = 1'b1;
            end
            if (r_en & st.empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign r_data      = r_data_q;
    assign r_valid     = r_valid_q;
    assign full        = st.full;
    assign empty       = st.empty;
    assign almost_full = st.almost_full;
    assign count       = cnt;
    assign overflow    = st.overflow;
    assign underflow   = st.underflow;

endmodule
